risc_spm_control_unit: RTL and testbench

Sequencing controller for the RISC-SPM processor. Fetches, decodes and executes one 8-bit instruction at a time by driving the register, bus-mux, ALU-flag and memory control lines. It sits directly downstream of the zero-flag register: it consumes that register's registered output on `zero` to resolve BRZ, and it issues the `load_reg_z` strobe that updates the flag.

---
 rtl/risc_spm_pkg.sv | 45 ++++
 rtl/ctrl_next_state.sv | 45 ++++
 rtl/risc_spm_control_unit.sv | 135 +++++++++++++
 tb/tb_risc_spm_control_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/risc_spm_pkg.sv
// rtl/risc_spm_pkg.sv - opcodes, state encoding, mux selects and instruction fields for the RISC-SPM controller
package risc_spm_pkg;

    localparam int WORD = 8;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int SRC_MSB = 3;
    localparam int SRC_LSB = 2;
    localparam int DST_MSB = 1;
    localparam int DST_LSB = 0;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_RD  = 4'd5;
    localparam logic [3:0] OP_WR  = 4'd6;
    localparam logic [3:0] OP_BR  = 4'd7;
    localparam logic [3:0] OP_BRZ = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_e;

    localparam logic [2:0] SEL1_R0 = 3'd0;
    localparam logic [2:0] SEL1_PC = 3'd4;

    localparam logic [1:0] SEL2_ALU  = 2'd0;
    localparam logic [1:0] SEL2_BUS1 = 2'd1;
    localparam logic [1:0] SEL2_MEM  = 2'd2;

endpackage

// File: rtl/ctrl_next_state.sv
// rtl/ctrl_next_state.sv - next-state logic; CTRL_HALT_ON_ILLEGAL_EN sends opcodes 9-15 to HALT
module ctrl_next_state
    import risc_spm_pkg::*;
(
    input  state_e     state,
    input  logic [3:0] opcode,
    input  logic       zero,
    output state_e     next_state
);

    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE: next_state = S_FET1;
            S_FET1: next_state = S_FET2;
            S_FET2: next_state = S_DEC;
            S_DEC: begin
                case (opcode)
                    OP_NOP:                 next_state = S_FET1;
                    OP_ADD, OP_SUB, OP_AND: next_state = S_EX1;
                    OP_NOT:                 next_state = S_FET1;
                    OP_RD:                  next_state = S_RD1;
                    OP_WR:                  next_state = S_WR1;
                    OP_BR:                  next_state = S_BR1;
                    OP_BRZ:                 next_state = zero ? S_BR1 : S_FET1;
`ifdef CTRL_HALT_ON_ILLEGAL_EN
                    default:                next_state = S_HALT;
`else
                    default:                next_state = S_FET1;
`endif
                endcase
            end
            S_EX1:  next_state = S_FET1;
            S_RD1:  next_state = S_RD2;
            S_RD2:  next_state = S_FET1;
            S_WR1:  next_state = S_WR2;
            S_WR2:  next_state = S_FET1;
            S_BR1:  next_state = S_BR2;
            S_BR2:  next_state = S_FET1;
            S_HALT: next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: rtl/risc_spm_control_unit.sv
// rtl/risc_spm_control_unit.sv - RISC-SPM sequencing controller; CTRL_HALT_ON_ILLEGAL_EN enables HALT on illegal opcodes
module risc_spm_control_unit
    import risc_spm_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] instruction,
    input  logic            zero,
    output logic            load_r0,
    output logic            load_r1,
    output logic            load_r2,
    output logic            load_r3,
    output logic            load_pc,
    output logic            inc_pc,
    output logic [2:0]      sel_bus_1_mux,
    output logic [1:0]      sel_bus_2_mux,
    output logic            load_ir,
    output logic            load_add_r,
    output logic            load_reg_y,
    output logic            load_reg_z,
    output logic            write
);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] opcode;
    logic [1:0] src;
    logic [1:0] dest;
    logic       load_dest;

    assign opcode = instruction[OPC_MSB:OPC_LSB];
    assign src    = instruction[SRC_MSB:SRC_LSB];
    assign dest   = instruction[DST_MSB:DST_LSB];

    ctrl_next_state u_next_state (
        .state      (state_q),
        .opcode     (opcode),
        .zero       (zero),
        .next_state (state_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        load_dest     = 1'b0;
        load_pc       = 1'b0;
        inc_pc        = 1'b0;
        sel_bus_1_mux = SEL1_R0;
        sel_bus_2_mux = SEL2_ALU;
        load_ir       = 1'b0;
        load_add_r    = 1'b0;
        load_reg_y    = 1'b0;
        load_reg_z    = 1'b0;
        write         = 1'b0;
        case (state_q)
            S_FET1: begin
                sel_bus_1_mux = SEL1_PC;
                load_add_r    = 1'b1;
            end
            S_FET2: begin
                sel_bus_2_mux = SEL2_MEM;
                load_ir       = 1'b1;
                inc_pc        = 1'b1;
            end
            S_DEC: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND: begin
                        sel_bus_1_mux = {1'b0, src};
                        load_reg_y    = 1'b1;
                    end
                    OP_NOT: begin
                        sel_bus_1_mux = {1'b0, src};
                        sel_bus_2_mux = SEL2_ALU;
                        load_reg_z    = 1'b1;
                        load_dest     = 1'b1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        sel_bus_1_mux = SEL1_PC;
                        load_add_r    = 1'b1;
                    end
                    OP_BRZ: begin
                        // Not-taken branch still has to step the PC past its operand word.
                        if (zero) begin
                            sel_bus_1_mux = SEL1_PC;
                            load_add_r    = 1'b1;
                        end else begin
                            inc_pc = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_EX1: begin
                sel_bus_1_mux = {1'b0, dest};
                sel_bus_2_mux = SEL2_ALU;
                load_reg_z    = 1'b1;
                load_dest     = 1'b1;
            end
            S_RD1, S_WR1: begin
                sel_bus_2_mux = SEL2_MEM;
                load_add_r    = 1'b1;
                inc_pc        = 1'b1;
            end
            S_RD2: begin
                sel_bus_2_mux = SEL2_MEM;
                load_dest     = 1'b1;
            end
            S_WR2: begin
                sel_bus_1_mux = {1'b0, src};
                write         = 1'b1;
            end
            S_BR1: begin
                sel_bus_2_mux = SEL2_MEM;
                load_add_r    = 1'b1;
            end
            S_BR2: begin
                sel_bus_2_mux = SEL2_MEM;
                load_pc       = 1'b1;
            end
            default: ;
        endcase
    end

    assign load_r0 = load_dest && (dest == 2'd0);
    assign load_r1 = load_dest && (dest == 2'd1);
    assign load_r2 = load_dest && (dest == 2'd2);
    assign load_r3 = load_dest && (dest == 2'd3);

endmodule

// File: tb/tb_risc_spm_control_unit.sv
// tb/tb_risc_spm_control_unit.sv - self-checking bench for risc_spm_control_unit
module tb_risc_spm_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] instruction = 8'h00;
    logic       zero = 1'b0;
    logic       load_r0, load_r1, load_r2, load_r3;
    logic       load_pc, inc_pc;
    logic [2:0] sel_bus_1_mux;
    logic [1:0] sel_bus_2_mux;
    logic       load_ir, load_add_r, load_reg_y, load_reg_z, write;

    int          checks = 0;
    int          errors = 0;
    bit          check_en = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] act;
    logic [15:0] e;

    risc_spm_control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .zero          (zero),
        .load_r0       (load_r0),
        .load_r1       (load_r1),
        .load_r2       (load_r2),
        .load_r3       (load_r3),
        .load_pc       (load_pc),
        .inc_pc        (inc_pc),
        .sel_bus_1_mux (sel_bus_1_mux),
        .sel_bus_2_mux (sel_bus_2_mux),
        .load_ir       (load_ir),
        .load_add_r    (load_add_r),
        .load_reg_y    (load_reg_y),
        .load_reg_z    (load_reg_z),
        .write         (write)
    );

    always #5 clk = ~clk;

    assign act = {load_r0, load_r1, load_r2, load_r3, load_pc, inc_pc, sel_bus_1_mux,
                  sel_bus_2_mux, load_ir, load_add_r, load_reg_y, load_reg_z, write};

    function automatic logic [15:0] ov(input logic [3:0] r, input logic pc, input logic inc,
                                       input logic [2:0] s1, input logic [1:0] s2, input logic ir,
                                       input logic ar, input logic y, input logic z, input logic w);
        return {r, pc, inc, s1, s2, ir, ar, y, z, w};
    endfunction

    // Appends the per-cycle control words of one whole instruction; returns its length.
    function automatic int model_push(input logic [7:0] ins, input logic zf);
        logic [3:0] op;
        logic [2:0] s;
        logic [2:0] d;
        logic [3:0] rd;
        int         n;
        op = ins[7:4];
        s  = {1'b0, ins[3:2]};
        d  = {1'b0, ins[1:0]};
        rd = 4'b1000 >> ins[1:0];
        n  = exp_q.size();
        exp_q.push_back(ov(4'h0, 1'b0, 1'b0, 3'd4, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(ov(4'h0, 1'b0, 1'b1, 3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        if (op >= 4'd1 && op <= 4'd3) begin
            exp_q.push_back(ov(4'h0, 1'b0, 1'b0, s, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(ov(rd, 1'b0, 1'b0, d, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        end else if (op == 4'd4) begin
            exp_q.push_back(ov(rd, 1'b0, 1'b0, s, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        end else if (op == 4'd5 || op == 4'd6 || op == 4'd7 || (op == 4'd8 && zf)) begin
            exp_q.push_back(ov(4'h0, 1'b0, 1'b0, 3'd4, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
            if (op == 4'd5) begin
                exp_q.push_back(ov(4'h0, 1'b0, 1'b1, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
                exp_q.push_back(ov(rd, 1'b0, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            end else if (op == 4'd6) begin
                exp_q.push_back(ov(4'h0, 1'b0, 1'b1, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
                exp_q.push_back(ov(4'h0, 1'b0, 1'b0, s, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            end else begin
                exp_q.push_back(ov(4'h0, 1'b0, 1'b0, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
                exp_q.push_back(ov(4'h0, 1'b1, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            end
        end else if (op == 4'd8) begin
            exp_q.push_back(ov(4'h0, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end else begin
            exp_q.push_back(16'h0000);
`ifdef CTRL_HALT_ON_ILLEGAL_EN
            if (op >= 4'd9) begin
                for (int i = 0; i < 20; i++) exp_q.push_back(16'h0000);
            end
`endif
        end
        return exp_q.size() - n;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cycle_underflow t=%0t act=%h no expected word", $time, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL cycle t=%0t ins=%h zero=%b act=%h exp=%h",
                             $time, instruction, zero, act, e);
                end
            end
        end
    end

    task automatic check_word(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, got, want);
        end
    endtask

    task automatic run_instr(input logic [7:0] ins, input logic zf, input int len,
                             input logic [15:0] last);
        int n;
        instruction = ins;
        zero        = zf;
        n = model_push(ins, zf);
        checks++;
        if (n != len) begin
            errors++;
            $display("FAIL model_len ins=%h act=%0d exp=%0d", ins, n, len);
        end
        check_word("model_last", exp_q[exp_q.size() - 1], last);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        #22;
        check_word("reset_idle", act, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_en    = 1'b1;
        instruction = 8'h1B;
        n = model_push(8'h1B, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check_en = 1'b0;
        rst      = 1'b0;
        #1;
        check_word("async_reset_ex1", act, 16'h0000);
        @(posedge clk);
        #1;
        check_word("reset_held", act, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_word("idle_after_release", act, 16'h0000);
        check_word("queue_drained", 16'(exp_q.size()), 16'h0000);
        @(posedge clk);
        #1;
        check_en = 1'b1;

        run_instr(8'h1B, 1'b0, 4, 16'h1182);
        run_instr(8'h26, 1'b0, 4, 16'h2102);
        run_instr(8'h3D, 1'b0, 4, 16'h4082);
        run_instr(8'h4E, 1'b0, 3, 16'h2182);
        run_instr(8'h57, 1'b0, 5, 16'h1040);
        run_instr(8'h64, 1'b0, 5, 16'h0081);
        run_instr(8'h70, 1'b0, 5, 16'h0840);
        run_instr(8'h25, 1'b0, 4, 16'h4082);
        run_instr(8'h80, 1'b1, 5, 16'h0840);
        run_instr(8'h80, 1'b0, 3, 16'h0400);
        run_instr(8'h00, 1'b0, 3, 16'h0000);
`ifdef CTRL_HALT_ON_ILLEGAL_EN
        run_instr(8'hF0, 1'b0, 23, 16'h0000);
`else
        run_instr(8'hF0, 1'b0, 3, 16'h0000);
        run_instr(8'h1B, 1'b0, 4, 16'h1182);
`endif
        check_en = 1'b0;
        check_word("queue_empty_end", 16'(exp_q.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
